m_progloader: RTL and testbench

- Serial program loader; the writer side of the 4K-word instruction memory that the processor fetches from.
- Receives a UART byte stream and assembles 32-bit big-endian words.
- Writes the words through the memory's write port (clock, we, 12-bit address, 32-bit data).
- Holds the processor in reset (w_busy) until the program image is complete.

---
 rtl/m_progloader_pkg.sv | 23 ++
 rtl/m_progloader_if.sv | 14 +
 rtl/m_progloader_uart_rx.sv | 108 ++++++++++
 rtl/m_progloader.sv | 106 ++++++++++
 tb/tb_m_progloader.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/m_progloader_pkg.sv
// rtl/m_progloader_pkg.sv - shared constants and state encodings for the program loader
package m_progloader_pkg;

    localparam int BIT_CYC_DEF   = 868;
    localparam int MEM_WORDS_DEF = 4096;
    localparam int HDR_BYTES     = 4;
    localparam int WORD_BYTES    = 4;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    typedef enum logic [1:0] {
        LD_HDR,
        LD_DATA,
        LD_DONE,
        LD_ERR
    } ld_state_t;

endpackage

// File: rtl/m_progloader_if.sv
// rtl/m_progloader_if.sv - instruction memory write port plus loader status
interface m_progloader_if;

    logic        w_we;
    logic [11:0] w_addr;
    logic [31:0] w_wdata;
    logic        w_busy;
    logic        w_done;
    logic        w_err;

    modport master (output w_we, w_addr, w_wdata, w_busy, w_done, w_err);
    modport slave  (input  w_we, w_addr, w_wdata, w_busy, w_done, w_err);

endinterface

// File: rtl/m_progloader_uart_rx.sv
// rtl/m_progloader_uart_rx.sv - 8N1 UART receiver with synchronizer and start-bit glitch filter
module m_uart_rx
    import m_progloader_pkg::*;
#(
    parameter int BIT_CYC = BIT_CYC_DEF
) (
    input  logic       w_clk,
    input  logic       w_rst,
    input  logic       w_rxd,
    output logic [7:0] rx_tdata,
    output logic       rx_tvalid,
    output logic       rx_ferr
);

    localparam int CW = $clog2(BIT_CYC) + 1;

    rx_state_t     state, state_nxt;
    logic          rxd_s1, rxd_s;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic          ld_half, ld_full, shift, emit, ferr;

    always_ff @(posedge w_clk) begin
        if (w_rst) begin
            state <= RX_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ld_half   = 1'b0;
        ld_full   = 1'b0;
        shift     = 1'b0;
        emit      = 1'b0;
        ferr      = 1'b0;
        case (state)
            RX_IDLE: begin
                if (!rxd_s) begin
                    state_nxt = RX_START;
                    ld_half   = 1'b1;
                end
            end
            RX_START: begin
                // Re-check mid-bit so short low pulses never start a frame
                if (cnt == '0) begin
                    if (!rxd_s) begin
                        state_nxt = RX_DATA;
                        ld_full   = 1'b1;
                    end else begin
                        state_nxt = RX_IDLE;
                    end
                end
            end
            RX_DATA: begin
                if (cnt == '0) begin
                    shift   = 1'b1;
                    ld_full = 1'b1;
                    if (bit_idx == 3'd7) begin
                        state_nxt = RX_STOP;
                    end
                end
            end
            RX_STOP: begin
                if (cnt == '0) begin
                    state_nxt = RX_IDLE;
                    emit      = rxd_s;
                    ferr      = !rxd_s;
                end
            end
            default: state_nxt = RX_IDLE;
        endcase
    end

    always_ff @(posedge w_clk) begin
        if (w_rst) begin
            rxd_s1    <= 1'b1;
            rxd_s     <= 1'b1;
            cnt       <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            rx_tvalid <= 1'b0;
            rx_ferr   <= 1'b0;
        end else begin
            rxd_s1    <= w_rxd;
            rxd_s     <= rxd_s1;
            rx_tvalid <= emit;
            rx_ferr   <= ferr;
            if (ld_half) begin
                cnt <= CW'(BIT_CYC / 2 - 1);
            end else if (ld_full) begin
                cnt <= CW'(BIT_CYC - 1);
            end else if (cnt != '0) begin
                cnt <= cnt - 1'b1;
            end
            // Eight shifts per frame wrap bit_idx back to zero on its own
            if (shift) begin
                shreg   <= {rxd_s, shreg[7:1]};
                bit_idx <= bit_idx + 1'b1;
            end
        end
    end

    assign rx_tdata = shreg;

endmodule

// File: rtl/m_progloader.sv
// rtl/m_progloader.sv - assembles a UART program image and writes it into instruction memory
module m_progloader
    import m_progloader_pkg::*;
#(
    parameter int BIT_CYC   = BIT_CYC_DEF,
    parameter int MEM_WORDS = MEM_WORDS_DEF
) (
    input  logic w_clk,
    input  logic w_rst,
    input  logic w_rxd,
    m_progloader_if.master mem
);

    ld_state_t   ld_state, ld_nxt;
    logic [7:0]  rx_tdata;
    logic        rx_tvalid, rx_ferr;
    logic [23:0] word_sr;
    logic [31:0] asm_word;
    logic [1:0]  byte_cnt;
    logic [12:0] n_words;
    logic        word_end, last_word;
    logic        we_q, busy_q, done_q, err_q;
    logic [11:0] addr_q;
    logic [31:0] wdata_q;

    m_uart_rx #(.BIT_CYC(BIT_CYC)) u_rx (
        .w_clk     (w_clk),
        .w_rst     (w_rst),
        .w_rxd     (w_rxd),
        .rx_tdata  (rx_tdata),
        .rx_tvalid (rx_tvalid),
        .rx_ferr   (rx_ferr)
    );

    assign asm_word  = {word_sr, rx_tdata};
    assign word_end  = rx_tvalid && (byte_cnt == 2'(WORD_BYTES - 1));
    assign last_word = ({1'b0, addr_q} == n_words - 13'd1);

    always_comb begin
        ld_nxt = ld_state;
        case (ld_state)
            LD_HDR: begin
                if (rx_tvalid && (byte_cnt == 2'(HDR_BYTES - 1))) begin
                    if (asm_word == '0) begin
                        ld_nxt = LD_DONE;
                    end else if (asm_word > 32'(MEM_WORDS)) begin
                        ld_nxt = LD_ERR;
                    end else begin
                        ld_nxt = LD_DATA;
                    end
                end
            end
            LD_DATA: begin
                if (we_q && last_word) begin
                    ld_nxt = LD_DONE;
                end
            end
            default: ld_nxt = ld_state;
        endcase
    end

    always_ff @(posedge w_clk) begin
        if (w_rst) begin
            ld_state <= LD_HDR;
            word_sr  <= '0;
            byte_cnt <= '0;
            n_words  <= '0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            busy_q   <= 1'b1;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            ld_state <= ld_nxt;
            we_q     <= 1'b0;
            done_q   <= (ld_nxt == LD_DONE);
            busy_q   <= (ld_nxt != LD_DONE);
            if (rx_ferr || (ld_nxt == LD_ERR)) begin
                err_q <= 1'b1;
            end
            if (rx_tvalid && (ld_state == LD_HDR || ld_state == LD_DATA)) begin
                word_sr  <= asm_word[23:0];
                byte_cnt <= byte_cnt + 1'b1;
            end
            if (ld_state == LD_HDR && word_end) begin
                n_words <= asm_word[12:0];
            end
            if (ld_state == LD_DATA && word_end) begin
                we_q    <= 1'b1;
                wdata_q <= asm_word;
            end
            if (we_q) begin
                addr_q <= addr_q + 1'b1;
            end
        end
    end

    assign mem.w_we    = we_q;
    assign mem.w_addr  = addr_q;
    assign mem.w_wdata = wdata_q;
    assign mem.w_busy  = busy_q;
    assign mem.w_done  = done_q;
    assign mem.w_err   = err_q;

endmodule

// File: tb/tb_m_progloader.sv
// tb/tb_m_progloader.sv - self-checking bench for m_progloader with a byte-level image model
module tb_m_progloader;

    localparam int BIT = 8;

    typedef struct {
        logic [11:0] a;
        logic [31:0] d;
    } wr_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rxd = 1'b1;

    m_progloader_if mem_if ();

    m_progloader #(.BIT_CYC(BIT), .MEM_WORDS(4096)) dut (
        .w_clk (clk),
        .w_rst (rst),
        .w_rxd (rxd),
        .mem   (mem_if)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [7:0]  acc[$];
    wr_t         exp_wr[$];
    wr_t         cap[$];
    logic [31:0] m_n;
    bit          m_done, m_err, m_dead;
    logic        prev_we = 1'b0;
    logic        prev_done = 1'b0;

    function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endfunction

    function automatic void model_clear();
        acc.delete();
        exp_wr.delete();
        cap.delete();
        m_n    = '0;
        m_done = 1'b0;
        m_err  = 1'b0;
        m_dead = 1'b0;
    endfunction

    // Image-level view: header is bytes 0..3, word k is bytes 4k+4..4k+7, big-endian
    function automatic void model_byte(input logic [7:0] b, input bit good);
        int sz;
        logic [31:0] k;
        wr_t w;
        if (!good) begin
            m_err = 1'b1;
            return;
        end
        if (m_done || m_dead) return;
        acc.push_back(b);
        sz = acc.size();
        if (sz == 4) begin
            m_n = {acc[0], acc[1], acc[2], acc[3]};
            if (m_n == 0) m_done = 1'b1;
            else if (m_n > 4096) begin
                m_err  = 1'b1;
                m_dead = 1'b1;
            end
        end else if (sz > 4 && sz % 4 == 0) begin
            k   = 32'(sz / 4 - 2);
            w.a = k[11:0];
            w.d = {acc[sz-4], acc[sz-3], acc[sz-2], acc[sz-1]};
            exp_wr.push_back(w);
            if (k == m_n - 1) m_done = 1'b1;
        end
    endfunction

    always @(negedge clk) begin
        wr_t e;
        if (!rst) begin
            check("busy_vs_done", mem_if.w_busy, !mem_if.w_done);
            if (mem_if.w_done && !prev_done && m_n != 0)
                check("done_after_last_we", prev_we, 1'b1);
            if (mem_if.w_we) begin
                if (exp_wr.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_we: got addr %0h data %0h expected no write",
                             mem_if.w_addr, mem_if.w_wdata);
                end else begin
                    e = exp_wr.pop_front();
                    check("we_addr", 32'(mem_if.w_addr), 32'(e.a));
                    check("we_data", mem_if.w_wdata, e.d);
                end
                e.a = mem_if.w_addr;
                e.d = mem_if.w_wdata;
                cap.push_back(e);
            end
        end
        prev_we   = mem_if.w_we;
        prev_done = mem_if.w_done;
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic tx_bit(input logic v);
        rxd = v;
        idle(BIT);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit good = 1'b1);
        model_byte(b, good);
        tx_bit(1'b0);
        for (int i = 0; i < 8; i++) tx_bit(b[i]);
        tx_bit(good);
        rxd = 1'b1;
        if (good) idle($urandom_range(1, 4));
        else idle(2 * BIT);
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 3; i >= 0; i--) send_byte(w[8*i +: 8]);
    endtask

    task automatic do_reset(input string nm);
        @(negedge clk);
        rst = 1'b1;
        rxd = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_clear();
        check({nm, "_rst_we"},    mem_if.w_we,    1'b0);
        check({nm, "_rst_addr"},  32'(mem_if.w_addr), 32'h0);
        check({nm, "_rst_wdata"}, mem_if.w_wdata, 32'h0);
        check({nm, "_rst_busy"},  mem_if.w_busy,  1'b1);
        check({nm, "_rst_done"},  mem_if.w_done,  1'b0);
        check({nm, "_rst_err"},   mem_if.w_err,   1'b0);
    endtask

    task automatic end_check(input string nm);
        idle(30);
        check({nm, "_done"}, mem_if.w_done, m_done);
        check({nm, "_busy"}, mem_if.w_busy, !m_done);
        check({nm, "_err"},  mem_if.w_err,  m_err);
        check({nm, "_pending_writes"}, exp_wr.size(), 0);
    endtask

    initial begin
        int n, bad_pos, pos;
        logic [31:0] w;

        model_clear();
        idle(2);
        do_reset("initial");

        // Two-word image
        send_word(32'h0000_0002);
        send_word(32'h0001_2020);
        send_word(32'h0022_2820);
        end_check("two_words");
        check("two_words_count", cap.size(), 2);
        if (cap.size() == 2) begin
            check("two_words_a0", 32'(cap[0].a), 32'h0);
            check("two_words_d0", cap[0].d, 32'h0001_2020);
            check("two_words_a1", 32'(cap[1].a), 32'h1);
            check("two_words_d1", cap[1].d, 32'h0022_2820);
        end
        check("two_words_lit_done", mem_if.w_done, 1'b1);
        check("two_words_lit_err",  mem_if.w_err,  1'b0);

        // Zero-length image
        do_reset("zero");
        send_word(32'h0);
        end_check("zero");
        check("zero_lit_done", mem_if.w_done, 1'b1);
        check("zero_lit_busy", mem_if.w_busy, 1'b0);
        check("zero_no_we", cap.size(), 0);

        // Oversize count, followed by bytes that must be ignored
        do_reset("oversize");
        send_word(32'h0000_1001);
        send_word(32'h1234_5678);
        send_word(32'h9ABC_DEF0);
        end_check("oversize");
        check("oversize_lit_err",  mem_if.w_err,  1'b1);
        check("oversize_lit_busy", mem_if.w_busy, 1'b1);
        check("oversize_no_we", cap.size(), 0);

        // Glitch then a one-word image: alignment must be unaffected
        do_reset("glitch");
        @(negedge clk);
        rxd = 1'b0;
        idle(2);
        rxd = 1'b1;
        idle(20);
        check("glitch_no_err", mem_if.w_err, 1'b0);
        send_word(32'h0000_0001);
        send_word(32'hDEAD_BEEF);
        end_check("glitch");
        check("glitch_lit_word", cap.size() == 1 ? cap[0].d : 32'hX, 32'hDEAD_BEEF);

        // Framing error inside an image: bad byte dropped, count unchanged
        do_reset("framing");
        send_word(32'h0000_0001);
        send_byte(8'h55, 1'b0);
        idle(4);
        check("framing_lit_err", mem_if.w_err, 1'b1);
        check("framing_no_we", cap.size(), 0);
        send_word(32'hAABB_CCDD);
        end_check("framing");
        check("framing_lit_word", cap.size() == 1 ? cap[0].d : 32'hX, 32'hAABB_CCDD);

        // Reset after six bytes, then a fresh one-word image lands at address 0
        do_reset("midload");
        send_word(32'h0000_0002);
        send_byte(8'h11);
        send_byte(8'h22);
        do_reset("midload_again");
        send_word(32'h0000_0001);
        send_word(32'hCAFE_BABE);
        end_check("midload");
        check("midload_lit_addr", cap.size() == 1 ? 32'(cap[0].a) : 32'hX, 32'h0);
        check("midload_lit_word", cap.size() == 1 ? cap[0].d : 32'hX, 32'hCAFE_BABE);

        // Randomized images, optional framing error, trailing bytes after completion
        for (int it = 0; it < 6; it++) begin
            do_reset("rand");
            n = $urandom_range(1, 3);
            bad_pos = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 4 + 4 * n - 1) : -1;
            pos = 0;
            send_word(32'(n));
            pos = 4;
            for (int k = 0; k < n; k++) begin
                w = $urandom;
                for (int i = 3; i >= 0; i--) begin
                    if (pos == bad_pos) send_byte(8'($urandom), 1'b0);
                    send_byte(w[8*i +: 8]);
                    pos++;
                end
            end
            for (int x = 0; x < 2; x++) send_byte(8'($urandom));
            end_check("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
